mux_scan_seq: RTL and testbench

Parametrised, registered N-to-1 multiplexer with a built-in channel scan sequencer; the next generation of the team's 8-to-1 enable-gated mux. It selects one of NCH W-bit channels, either from an external select (manual mode) or from an internal round-robin pointer that dwells a programmable number of cycles per channel (auto mode). It sits between a bank of sensor/data channels and a single shared downstream consumer, and tags each output sample with its channel index and a valid flag.

---
 rtl/mux_scan_seq.sv | 103 ++++++++++
 tb/tb_mux_scan_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_seq.sv
// Registered N-to-1 channel mux with a round-robin scan sequencer.
// Each output sample carries its channel index, a valid flag and an end-of-scan pulse.
module mux_scan_seq #(
  parameter int unsigned NCH     = 8,
  parameter int unsigned W       = 1,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned SW     = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               EN,
  input  logic               mode,
  input  logic [SW-1:0]      sel_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH*W-1:0]   x,
  output logic [W-1:0]       f,
  output logic [SW-1:0]      sel_out,
  output logic               valid,
  output logic               wrap
);

  // One extra bit so NCH itself is representable when NCH is a power of two.
  localparam logic [SW:0]   NchExt = (SW+1)'(NCH);
  localparam logic [SW-1:0] LastCh = SW'(NCH - 1);

  logic [SW-1:0]      ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]       f_q, f_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  logic [SW-1:0] cur;
  logic          cur_ok;
  logic          sel_ok;
  logic [W-1:0]  cur_data;

  always_comb begin
    cur      = mode ? ptr_q : sel_in;
    cur_ok   = {1'b0, cur} < NchExt;
    sel_ok   = {1'b0, sel_in} < NchExt;
    cur_data = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cur == SW'(i)) cur_data = x[i*W +: W];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    wrap_d  = wrap_q;
    if (EN) begin
      // An out-of-range manual select still reports its index, just not as valid.
      f_d     = cur_ok ? cur_data : '0;
      sel_d   = cur;
      valid_d = cur_ok;
      if (!mode) begin
        // Tracking sel_in lets a later switch to auto start on the last manual channel.
        ptr_d  = sel_ok ? sel_in : '0;
        cnt_d  = '0;
        wrap_d = 1'b0;
      end else if (cnt_q >= dwell) begin
        ptr_d  = (ptr_q == LastCh) ? '0 : ptr_q + SW'(1);
        cnt_d  = '0;
        wrap_d = (ptr_q == LastCh);
      end else begin
        cnt_d  = cnt_q + DWELL_W'(1);
        wrap_d = 1'b0;
      end
    end else begin
      f_d     = '0;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign f       = f_q;
  assign sel_out = sel_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: directed scenarios plus randomized traffic against a reference model.
module tb_mux_scan_seq;
  localparam int NCH = 8;
  localparam int W   = 4;
  localparam int DW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mode;
  logic [2:0]  sel_in;
  logic [3:0]  dwell;
  logic [31:0] x;
  logic [3:0]  f;
  logic [2:0]  sel_out;
  logic        valid, wrap;

  logic        b_rst, b_en, b_mode;
  logic [2:0]  b_sel;
  logic [3:0]  b_dwell;
  logic [19:0] b_x;
  logic [3:0]  b_f;
  logic [2:0]  b_sel_out;
  logic        b_valid, b_wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic [3:0] e_f = '0;
  logic [2:0] e_sel = '0;
  logic       e_valid = 1'b0;
  logic       e_wrap = 1'b0;

  mux_scan_seq #(.NCH(NCH), .W(W), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .EN(en), .mode(mode), .sel_in(sel_in), .dwell(dwell), .x(x),
    .f(f), .sel_out(sel_out), .valid(valid), .wrap(wrap)
  );

  mux_scan_seq #(.NCH(5), .W(W), .DWELL_W(DW)) dut5 (
    .clk(clk), .rst(b_rst), .EN(b_en), .mode(b_mode), .sel_in(b_sel), .dwell(b_dwell),
    .x(b_x), .f(b_f), .sel_out(b_sel_out), .valid(b_valid), .wrap(b_wrap)
  );

  function automatic logic [31:0] default_x();
    logic [31:0] v;
    for (int i = 0; i < NCH; i++) v[i*4 +: 4] = 4'(i + 3);
    return v;
  endfunction

  // Applies the documented per-edge rules using the inputs present before the edge.
  task automatic model_step();
    int cur;
    if (rst) begin
      m_ptr = 0; m_cnt = 0;
      e_f = '0; e_sel = '0; e_valid = 1'b0; e_wrap = 1'b0;
    end else if (!en) begin
      e_f = '0; e_valid = 1'b0; e_wrap = 1'b0;
    end else begin
      cur = mode ? m_ptr : int'(sel_in);
      if (cur < NCH) begin
        e_f = x[cur*4 +: 4]; e_sel = 3'(cur); e_valid = 1'b1;
      end else begin
        e_f = '0; e_sel = sel_in; e_valid = 1'b0;
      end
      if (!mode) begin
        m_ptr = (int'(sel_in) < NCH) ? int'(sel_in) : 0;
        m_cnt = 0;
        e_wrap = 1'b0;
      end else if (m_cnt >= int'(dwell)) begin
        e_wrap = (m_ptr == NCH - 1);
        m_ptr = (m_ptr + 1) % NCH;
        m_cnt = 0;
      end else begin
        m_cnt++;
        e_wrap = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'($urandom); mode = 1'($urandom); sel_in = 3'($urandom);
    dwell = 4'($urandom); x = $urandom;
    cyc();
    cyc();
    n_checks++;
    if (f !== 4'd0 || sel_out !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: got f=%0d sel=%0d v=%0b w=%0b want 0 0 0 0", f, sel_out, valid, wrap);
    end
    rst = 1'b0; en = 1'b1; mode = 1'b0; sel_in = 3'd5; x = default_x();
    cyc();
    n_checks++;
    if (f !== 4'd8 || sel_out !== 3'd5 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL first_sample: got f=%0d sel=%0d v=%0b want 8 5 1", f, sel_out, valid);
    end
  endtask

  task automatic test_manual_sweep();
    for (int s = 0; s < NCH; s++) begin
      sel_in = 3'(s);
      cyc();
      n_checks++;
      if (f !== 4'(s + 3) || sel_out !== 3'(s) || valid !== 1'b1 || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL manual_sweep[%0d]: got f=%0d sel=%0d v=%0b w=%0b want %0d %0d 1 0",
                 s, f, sel_out, valid, wrap, s + 3, s);
      end
    end
    en = 1'b0;
    cyc();
    n_checks++;
    if (f !== 4'd0 || valid !== 1'b0 || sel_out !== 3'd7) begin
      n_errors++;
      $display("FAIL manual_disable: got f=%0d v=%0b sel=%0d want 0 0 7", f, valid, sel_out);
    end
  endtask

  task automatic test_auto();
    en = 1'b1; mode = 1'b1; dwell = 4'd2; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      cyc();
      n_checks++;
      if (sel_out !== 3'((n / 3) % 8) || wrap !== 1'(n % 24 == 23) || valid !== 1'b1 ||
          f !== 4'((n / 3) % 8 + 3)) begin
        n_errors++;
        $display("FAIL auto_dwell2[%0d]: got sel=%0d w=%0b v=%0b f=%0d want sel=%0d w=%0b",
                 n, sel_out, wrap, valid, f, (n / 3) % 8, (n % 24 == 23));
      end
    end
    dwell = 4'd0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 17; n++) begin
      cyc();
      n_checks++;
      if (sel_out !== 3'(n % 8) || wrap !== 1'(n % 8 == 7)) begin
        n_errors++;
        $display("FAIL auto_dwell0[%0d]: got sel=%0d w=%0b want sel=%0d w=%0b",
                 n, sel_out, wrap, n % 8, (n % 8 == 7));
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [2:0] exp_sel [6];
    logic       exp_wrap [6];
    exp_sel  = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    en = 1'b1; mode = 1'b0; sel_in = 3'd6;
    for (int i = 0; i < 3; i++) cyc();
    mode = 1'b1; dwell = 4'd1; sel_in = 3'($urandom);
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (sel_out !== exp_sel[i] || wrap !== exp_wrap[i] || valid !== 1'b1) begin
        n_errors++;
        $display("FAIL mode_switch[%0d]: got sel=%0d w=%0b v=%0b want sel=%0d w=%0b",
                 i, sel_out, wrap, valid, exp_sel[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_disrupt();
    logic [2:0] exp_sel [7];
    exp_sel = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5};
    en = 1'b1; mode = 1'b1; dwell = 4'd3; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    n_checks++;
    if (sel_out !== 3'd2) begin
      n_errors++;
      $display("FAIL pre_stall: got sel=%0d want 2", sel_out);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (valid !== 1'b0 || f !== 4'd0 || sel_out !== 3'd2 || wrap !== 1'b0) begin
        n_errors++;
        $display("FAIL stall[%0d]: got v=%0b f=%0d sel=%0d w=%0b want 0 0 2 0",
                 i, valid, f, sel_out, wrap);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) dwell = 4'd0;
      cyc();
      n_checks++;
      if (sel_out !== exp_sel[i] || valid !== 1'b1) begin
        n_errors++;
        $display("FAIL resume_dwell_drop[%0d]: got sel=%0d v=%0b want sel=%0d",
                 i, sel_out, valid, exp_sel[i]);
      end
    end
    dwell = 4'd3; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) cyc();
    n_checks++;
    if (sel_out !== 3'd4) begin
      n_errors++;
      $display("FAIL pre_midreset: got sel=%0d want 4", sel_out);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (sel_out !== 3'(i / 4) || valid !== 1'b1) begin
        n_errors++;
        $display("FAIL after_midreset[%0d]: got sel=%0d v=%0b want sel=%0d",
                 i, sel_out, valid, i / 4);
      end
    end
  endtask

  task automatic test_random();
    x = $urandom;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel_in = 3'($urandom);
      if ($urandom_range(0, 9) == 0) dwell = 4'($urandom_range(0, 4));
      x = $urandom;
      cyc();
      n_checks++;
      if (f !== e_f || sel_out !== e_sel || valid !== e_valid || wrap !== e_wrap) begin
        n_errors++;
        $display("FAIL random[%0d]: got f=%0d sel=%0d v=%0b w=%0b want f=%0d sel=%0d v=%0b w=%0b",
                 i, f, sel_out, valid, wrap, e_f, e_sel, e_valid, e_wrap);
      end
    end
  endtask

  task automatic test_npot();
    for (int i = 0; i < 5; i++) b_x[i*4 +: 4] = 4'(i + 3);
    b_rst = 1'b1; b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd6; b_dwell = 4'd0;
    cyc();
    b_rst = 1'b0;
    cyc();
    n_checks++;
    if (b_valid !== 1'b0 || b_f !== 4'd0 || b_sel_out !== 3'd6) begin
      n_errors++;
      $display("FAIL npot_oob: got v=%0b f=%0d sel=%0d want 0 0 6", b_valid, b_f, b_sel_out);
    end
    b_sel = 3'd4;
    cyc();
    n_checks++;
    if (b_valid !== 1'b1 || b_f !== 4'd7 || b_sel_out !== 3'd4) begin
      n_errors++;
      $display("FAIL npot_last: got v=%0b f=%0d sel=%0d want 1 7 4", b_valid, b_f, b_sel_out);
    end
    b_rst = 1'b1; b_mode = 1'b1;
    cyc();
    b_rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      cyc();
      n_checks++;
      if (b_sel_out !== 3'(n % 5) || b_wrap !== 1'(n % 5 == 4) || b_f !== 4'(n % 5 + 3) ||
          b_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL npot_scan[%0d]: got sel=%0d w=%0b f=%0d want sel=%0d w=%0b f=%0d",
                 n, b_sel_out, b_wrap, b_f, n % 5, (n % 5 == 4), n % 5 + 3);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_in = '0; dwell = '0; x = '0;
    b_rst = 1'b1; b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_dwell = '0; b_x = '0;
    test_reset();
    test_manual_sweep();
    test_auto();
    test_mode_switch();
    test_disrupt();
    test_random();
    test_npot();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
